// File: rtl/reset_pkg.sv
// Shared definitions for the reset sequencer: FSM state type and reset-cause codes.
package reset_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   localparam logic [1:0] CAUSE_POR = 2'b01;
   localparam logic [1:0] CAUSE_SW  = 2'b10;

endpackage : reset_pkg

// File: rtl/reset_sequencer.sv
// Releases N_STAGES reset domains one at a time, STAGE_DLY cycles apart, after
// power-on reset or an accepted software reset request.
// Ports:
//   clk        - single clock
//   arst_n     - async active-low reset (deassertion already synchronous to clk)
//   sw_rst_req - software reset request, level-sampled, honoured only in RUN
//   sw_rst_ack - one-cycle pulse when a software request is accepted
//   rst_n_o    - active-low per-domain resets, bit 0 released first
//   rst_done   - high while all domains are released
//   rst_cause  - cause of the last reset (01 POR, 10 SW)
module reset_sequencer
   import reset_pkg::*;
#(
   parameter int N_STAGES  = 3,
   parameter int STAGE_DLY = 16
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic                sw_rst_req,
   output logic                sw_rst_ack,
   output logic [N_STAGES-1:0] rst_n_o,
   output logic                rst_done,
   output logic [1:0]          rst_cause
);

   // Guarded so an illegal parameter reaches the error below instead of a zero-width vector.
   localparam int unsigned CNT_W = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
   localparam int unsigned IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

   if (N_STAGES < 1 || N_STAGES > 8) begin : g_bad_n_stages
      $error("reset_sequencer: N_STAGES must be within 1..8");
   end
   if (STAGE_DLY < 2) begin : g_bad_stage_dly
      $error("reset_sequencer: STAGE_DLY must be at least 2");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DLY - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STAGES - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [IDX_W-1:0]    idx_q,   idx_d;
   logic [N_STAGES-1:0] rstn_q,  rstn_d;
   logic                done_q,  done_d;
   logic                ack_q,   ack_d;
   logic [1:0]          cause_q, cause_d;

   // State and output registers; reset forces the start of a POR sequence.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= ST_ASSERT;
         cnt_q   <= '0;
         idx_q   <= '0;
         rstn_q  <= '0;
         done_q  <= 1'b0;
         ack_q   <= 1'b0;
         cause_q <= CAUSE_POR;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rstn_q  <= rstn_d;
         done_q  <= done_d;
         ack_q   <= ack_d;
         cause_q <= cause_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rstn_d  = rstn_q;
      done_d  = done_q;
      ack_d   = 1'b0;
      cause_d = cause_q;

      case (state_q)
         ST_ASSERT: begin
            rstn_d = '0;
            done_d = 1'b0;
            if (cnt_q == CNT_LAST) begin
               rstn_d = N_STAGES'(1);
               cnt_d  = '0;
               idx_d  = IDX_W'(1);
               if (N_STAGES == 1) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RELEASE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RELEASE: begin
            if (cnt_q == CNT_LAST) begin
               // Only the currently indexed stage is released on this edge.
               for (int unsigned i = 0; i < N_STAGES; i++) begin
                  if (idx_q == IDX_W'(i)) begin
                     rstn_d[i] = 1'b1;
                  end
               end
               cnt_d = '0;
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RUN: begin
            if (sw_rst_req) begin
               state_d = ST_ASSERT;
               rstn_d  = '0;
               done_d  = 1'b0;
               cnt_d   = '0;
               idx_d   = '0;
               ack_d   = 1'b1;
               cause_d = CAUSE_SW;
            end
         end

         default: begin
            state_d = ST_ASSERT;
            rstn_d  = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   assign rst_n_o    = rstn_q;
   assign rst_done   = done_q;
   assign sw_rst_ack = ack_q;
   assign rst_cause  = cause_q;

endmodule : reset_sequencer

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance (3 stages, 16 cycles) and a
// minimal one (1 stage, 2 cycles) share stimulus; each has a time-based model.
module tb_reset_sequencer;

   localparam int NA = 3;
   localparam int DA = 16;
   localparam int NB = 1;
   localparam int DB = 2;

   typedef struct packed {
      logic [7:0] rstn;
      logic       done;
      logic       ack;
      logic [1:0] cause;
   } obs_t;

   logic clk;
   logic arst_n;
   logic sw_rst_req;

   logic [NA-1:0] rstn_a;
   logic          done_a, ack_a;
   logic [1:0]    cause_a;
   logic [NB-1:0] rstn_b;
   logic          done_b, ack_b;
   logic [1:0]    cause_b;

   reset_sequencer #(.N_STAGES(NA), .STAGE_DLY(DA)) u_dut_a (
      .clk        (clk),
      .arst_n     (arst_n),
      .sw_rst_req (sw_rst_req),
      .sw_rst_ack (ack_a),
      .rst_n_o    (rstn_a),
      .rst_done   (done_a),
      .rst_cause  (cause_a)
   );

   reset_sequencer #(.N_STAGES(NB), .STAGE_DLY(DB)) u_dut_b (
      .clk        (clk),
      .arst_n     (arst_n),
      .sw_rst_req (sw_rst_req),
      .sw_rst_ack (ack_b),
      .rst_n_o    (rstn_b),
      .rst_done   (done_b),
      .rst_cause  (cause_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   obs_t act_a, act_b;
   assign act_a = {8'(rstn_a), done_a, ack_a, cause_a};
   assign act_b = {8'(rstn_b), done_b, ack_b, cause_b};

   // Expected outputs t edges into a sequence: stage i is free once t reaches (i+1)*d.
   function automatic obs_t model_out(int t, int n, int d, logic [1:0] cause, logic ack);
      obs_t o;
      o.rstn = '0;
      for (int i = 0; i < n; i++) begin
         if (t >= (i + 1) * d) o.rstn[i] = 1'b1;
      end
      o.done  = (t >= n * d);
      o.ack   = ack;
      o.cause = cause;
      return o;
   endfunction

   obs_t rst_obs;
   initial rst_obs = '{rstn: 8'h00, done: 1'b0, ack: 1'b0, cause: 2'b01};

   task automatic check(input string name, input obs_t act, input obs_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got rstn=%b done=%b ack=%b cause=%b, want rstn=%b done=%b ack=%b cause=%b",
                  name, $time, act.rstn, act.done, act.ack, act.cause,
                  exp.rstn, exp.done, exp.ack, exp.cause);
      end
   endtask

   // Reference models: one sequence timer per instance, pushed to a scoreboard queue.
   obs_t qa[$];
   obs_t qb[$];
   int   ta = 0, tb = 0;
   logic [1:0] ca = 2'b01, cb = 2'b01;
   logic       ka, kb;

   always @(posedge clk) begin
      if (!arst_n) begin
         ta = 0; ca = 2'b01; ka = 1'b0;
         tb = 0; cb = 2'b01; kb = 1'b0;
      end else begin
         if (ta >= NA * DA && sw_rst_req) begin
            ta = 0; ca = 2'b10; ka = 1'b1;
         end else begin
            if (ta < NA * DA) ta++;
            ka = 1'b0;
         end
         if (tb >= NB * DB && sw_rst_req) begin
            tb = 0; cb = 2'b10; kb = 1'b1;
         end else begin
            if (tb < NB * DB) tb++;
            kb = 1'b0;
         end
      end
      qa.push_back(model_out(ta, NA, DA, ca, ka));
      qb.push_back(model_out(tb, NB, DB, cb, kb));
   end

   // An async reset overrides whatever the pending cycle was expected to show.
   always @(negedge arst_n) begin
      if (qa.size() > 0) qa[qa.size() - 1] = rst_obs;
      if (qb.size() > 0) qb[qb.size() - 1] = rst_obs;
   end

   // Monitor: compare every presented cycle away from the active edge.
   always @(negedge clk) begin
      obs_t e;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         check("dut_a", act_a, e);
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         check("dut_b", act_b, e);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle reset assertion: outputs must drop without waiting for clk.
   task automatic pulse_arst(input int hold);
      arst_n = 1'b0;
      #1;
      check("async_a", act_a, rst_obs);
      check("async_b", act_b, rst_obs);
      repeat (hold) @(posedge clk);
      #1;
      arst_n = 1'b1;
   endtask

   initial begin
      arst_n     = 1'b0;
      sw_rst_req = 1'b0;
      repeat (3) step();
      arst_n = 1'b1;

      // POR with an ignored request sampled at edge 20.
      repeat (19) step();
      sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      repeat (40) step();

      // Single-cycle software request in RUN.
      sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      repeat (55) step();

      // Restart, then reset again at edge 40 (rst_n_o = 011).
      pulse_arst(2);
      repeat (40) step();
      pulse_arst(2);
      repeat (60) step();

      // Request held high: one ack per completed sequence.
      sw_rst_req = 1'b1;
      repeat (200) step();
      sw_rst_req = 1'b0;
      repeat (60) step();

      // Randomised requests with occasional async resets.
      for (int i = 0; i < 1500; i++) begin
         sw_rst_req = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 199) == 0) pulse_arst(int'($urandom_range(1, 3)));
         else step();
      end
      sw_rst_req = 1'b0;
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_reset_sequencer
